// File: rtl/gate_sweep_checker.sv
// Exhaustive sweep driver and response checker for a small combinational gate.
// Drives every input vector in binary order, compares the gate output with EXPECTED and reports the results.
`timescale 1ns/1ps
module gate_sweep_checker #(
  parameter int                    N_IN       = 2,
  parameter logic [(2**N_IN)-1:0]  EXPECTED   = 4'b0111,
  parameter int                    SETTLE_CYC = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  output logic [N_IN-1:0] stim,
  input  logic            dut_out,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_count,
  output logic            fail_valid,
  output logic [N_IN-1:0] fail_idx
);

  localparam logic [1:0]      IDLE        = 2'd0;
  localparam logic [1:0]      RUN         = 2'd1;
  localparam logic [1:0]      DONE        = 2'd2;
  localparam logic [3:0]      SETTLE_LOAD = 4'(SETTLE_CYC - 1);
  localparam logic [N_IN-1:0] LAST_IDX    = '1;

  logic [1:0]      state_reg;
  logic [N_IN-1:0] idx_reg;
  logic [3:0]      settle_reg;
  logic            mismatch;
  logic [N_IN:0]   err_next;

  assign mismatch = (dut_out != EXPECTED[idx_reg]);
  // Includes the vector being sampled now, so pass reflects the final vector too.
  assign err_next = err_count + {{N_IN{1'b0}}, mismatch};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      idx_reg    <= '0;
      settle_reg <= '0;
      stim       <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_count  <= '0;
      fail_valid <= 1'b0;
      fail_idx   <= '0;
    end else begin
      case (state_reg)
        IDLE, DONE: begin
          if (start) begin
            state_reg  <= RUN;
            idx_reg    <= '0;
            stim       <= '0;
            settle_reg <= SETTLE_LOAD;
            err_count  <= '0;
            fail_valid <= 1'b0;
            fail_idx   <= '0;
            busy       <= 1'b1;
            done       <= 1'b0;
            pass       <= 1'b0;
          end
        end
        RUN: begin
          if (settle_reg != 4'd0) begin
            settle_reg <= settle_reg - 4'd1;
          end else begin
            err_count <= err_next;
            if (mismatch && !fail_valid) begin
              fail_idx   <= idx_reg;
              fail_valid <= 1'b1;
            end
            if (idx_reg != LAST_IDX) begin
              idx_reg    <= idx_reg + 1'b1;
              stim       <= idx_reg + 1'b1;
              settle_reg <= SETTLE_LOAD;
            end else begin
              state_reg <= DONE;
              busy      <= 1'b0;
              done      <= 1'b1;
              stim      <= '0;
              pass      <= (err_next == '0);
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule
